// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the RV32I data-memory controller.
// Also used by the load formatter, which the icache fill path will reuse.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Byte enables for a store of the given size at byte offset a within the word.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << a;
      SZ_H:    be = 4'b0011 << {a[1], 1'b0};
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data onto every lane it could land in.
  function automatic logic [31:0] lane_gen(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SZ_B:    lanes = {4{wdata[7:0]}};
      SZ_H:    lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      SZ_H:    bad = a[0];
      SZ_W:    bad = (a != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// Combinational load formatter: selects the byte/half/word from a RAM word
// and sign- or zero-extends it to 32 bits.
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    case (size)
      SZ_B:    result = {{24{byte_sel[7] & ~zero_ext}}, byte_sel};
      SZ_H:    result = {{16{half_sel[15] & ~zero_ext}}, half_sel};
      SZ_W:    result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-lane block RAM behind a valid/ready request port
// and a registered, backpressure-holding response port with fault reporting.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
  localparam state_t      ACC_STATE = (READ_LAT == 2) ? WAIT : RESP;

  state_t      state_reg, state_next;
  logic        resp_valid_reg;
  logic        accept;
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        fault;
  logic [3:0]  be;
  logic [31:0] lanes;
  logic        wr_en, rd_en;

  logic [3:0][7:0] mem [DEPTH_WORDS];
  logic [31:0] ram_q;
  logic [31:0] fmt_word;
  logic [31:0] fmt_result;

  // Response metadata captured at accept
  logic        rsp_we_reg;
  logic        rsp_err_reg;
  logic        rsp_zext_reg;
  logic [1:0]  rsp_size_reg;
  logic [1:0]  rsp_off_reg;

  assign req_ready = rst_n && ((state_reg == IDLE) || (state_reg == RESP && resp_ready));
  assign accept    = req_valid && req_ready;

  assign off   = req_addr - BASE_ADDR;
  assign idx   = off[AW+1:2];
  assign fault = (req_size == 2'b11) || misaligned(req_size, req_addr[1:0]) || (off >= SPAN);
  assign be    = be_gen(req_size, req_addr[1:0]);
  assign lanes = lane_gen(req_size, req_wdata);
  assign wr_en = accept && req_we && !fault;
  assign rd_en = accept && !req_we;

  // RAM has no reset; committed stores survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i] <= lanes[8*i +: 8];
      end
    end
    if (rd_en) ram_q <= mem[idx];
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [31:0] ram_q2;
      always_ff @(posedge clk) begin
        if (state_reg == WAIT) ram_q2 <= ram_q;
      end
      assign fmt_word = ram_q2;
    end else begin : g_lat1
      assign fmt_word = ram_q;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ACC_STATE;
      WAIT:    state_next = RESP;
      RESP:    if (resp_ready) state_next = accept ? ACC_STATE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      resp_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      resp_valid_reg <= (state_next == RESP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_we_reg   <= 1'b0;
      rsp_err_reg  <= 1'b0;
      rsp_zext_reg <= 1'b0;
      rsp_size_reg <= 2'b00;
      rsp_off_reg  <= 2'b00;
    end else if (accept) begin
      rsp_we_reg   <= req_we;
      rsp_err_reg  <= fault;
      rsp_zext_reg <= req_unsigned;
      rsp_size_reg <= req_size;
      rsp_off_reg  <= req_addr[1:0];
    end
  end

  dmem_load_fmt u_fmt (
    .word     (fmt_word),
    .offset   (rsp_off_reg),
    .size     (rsp_size_reg),
    .zero_ext (rsp_zext_reg),
    .result   (fmt_result)
  );

  // Read data and metadata only change on a new accept, so the response holds under backpressure.
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_valid_reg && rsp_err_reg;
  assign resp_rdata = (resp_valid_reg && !rsp_we_reg && !rsp_err_reg) ? fmt_result : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: byte-array reference model, randomized traffic,
// directed extension/fault/backpressure/reset cases, and a READ_LAT=2 instance.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int unsigned SPAN  = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_req_unsigned = 1'b0;
  logic [1:0]  b_req_size = 2'b00;
  logic [31:0] b_req_addr = 32'h0, b_req_wdata = 32'h0;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic        b_resp_ready = 1'b1;
  logic [31:0] b_resp_rdata;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LAT(2)) dut_lat2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we), .req_size(b_req_size),
    .req_unsigned(b_req_unsigned), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         bp_mode = 0;  // 0 random resp_ready, 1 forced low, 2 forced high
  logic [7:0] ref_mem [SPAN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, rules applied directly to the access.
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    logic [31:0] off;
    logic [31:0] val;
    int nb;
    off = a - BASE;
    rd  = 32'h0;
    err = 1'b0;
    case (sz)
      2'b00:   nb = 1;
      2'b01:   nb = 2;
      2'b10:   nb = 4;
      default: begin nb = 1; err = 1'b1; end
    endcase
    if (off >= SPAN) err = 1'b1;
    if ((a % 32'(nb)) != 0) err = 1'b1;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(off) + i] = wd[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_mem[int'(off) + i];
        if (nb < 4 && !uns && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
        rd = val;
      end
    end
  endfunction

  // Drive at the falling edge; the request is taken at the next rising edge once req_ready is seen.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input string tag, input bit use_exp,
                       input logic [31:0] x_rd, input logic x_err);
    logic [31:0] m_rd;
    logic        m_err;
    exp_t        e;
    int          n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready) begin
      @(negedge clk);
      n++;
      if (n >= 200) begin
        n_checks++; n_fail++;
        $display("FAIL %s: req_ready stayed 0 for 200 cycles, required 1", tag);
        req_valid = 1'b0;
        return;
      end
    end
    model(we, sz, uns, a, wd, m_rd, m_err);
    e.rdata = use_exp ? x_rd : m_rd;
    e.err   = use_exp ? x_err : m_err;
    e.tag   = tag;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic issue_m(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input string tag);
    issue(we, sz, uns, a, wd, tag, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        1:       resp_ready = 1'b0;
        2:       resp_ready = 1'b1;
        default: resp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops on every response handshake, and checks held responses stay stable.
  initial begin
    logic        held;
    logic [31:0] h_rdata;
    logic        h_err;
    exp_t        e;
    held = 1'b0; h_rdata = 32'h0; h_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !resp_valid) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_rdata", resp_rdata, h_rdata);
          chk1("hold_err", resp_err, h_err);
        end
        if (resp_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_resp: got rdata=%h err=%b, required no response", resp_rdata, resp_err);
          end else begin
            e = exp_q.pop_front();
            if (resp_rdata !== e.rdata || resp_err !== e.err) begin
              n_fail++;
              $display("FAIL %s: got rdata=%h err=%b, required rdata=%h err=%b",
                       e.tag, resp_rdata, resp_err, e.rdata, e.err);
            end else begin
              $display("resp %s rdata=%h err=%b", e.tag, resp_rdata, resp_err);
            end
          end
          held = 1'b0;
        end else begin
          held = 1'b1; h_rdata = resp_rdata; h_err = resp_err;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic lat2_test();
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = SZ_W; b_req_addr = 32'h40; b_req_wdata = 32'h1234_5678;
    chk1("l2_idle_ready", b_req_ready, 1'b1);
    @(negedge clk);
    chk1("l2_wait_ready", b_req_ready, 1'b0);
    chk1("l2_wait_valid", b_resp_valid, 1'b0);
    b_req_we = 1'b0; b_req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk1("l2_st_valid", b_resp_valid, 1'b1);
    chk1("l2_st_err", b_resp_err, 1'b0);
    chk("l2_st_rdata", b_resp_rdata, 32'h0);
    chk1("l2_resp_ready", b_req_ready, 1'b1);
    @(negedge clk);
    b_req_valid = 1'b0;
    chk1("l2_ld_wait_valid", b_resp_valid, 1'b0);
    chk1("l2_ld_wait_ready", b_req_ready, 1'b0);
    @(negedge clk);
    chk1("l2_ld_valid", b_resp_valid, 1'b1);
    chk("l2_ld_rdata", b_resp_rdata, 32'h1234_5678);
    chk1("l2_ld_err", b_resp_err, 1'b0);
    @(negedge clk);
    chk1("l2_idle_valid", b_resp_valid, 1'b0);
    chk1("l2_idle_ready2", b_req_ready, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk1("rst_resp_err", resp_err, 1'b0);
    chk1("rst_l2_resp_valid", b_resp_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_release_ready", req_ready, 1'b1);

    lat2_test();

    for (int w = 0; w < int'(DEPTH); w++) issue_m(1'b1, SZ_W, 1'b0, BASE + 32'(4*w), $urandom, "init_sw");

    issue(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEAD_BEEF, "sw_10", 1'b1, 32'h0, 1'b0);
    issue(1'b0, SZ_B, 1'b0, 32'h13, 32'h0, "lb_13", 1'b1, 32'hFFFF_FFDE, 1'b0);
    issue(1'b0, SZ_B, 1'b1, 32'h13, 32'h0, "lbu_13", 1'b1, 32'h0000_00DE, 1'b0);
    issue(1'b0, SZ_H, 1'b0, 32'h12, 32'h0, "lh_12", 1'b1, 32'hFFFF_DEAD, 1'b0);
    issue(1'b0, SZ_H, 1'b1, 32'h10, 32'h0, "lhu_10", 1'b1, 32'h0000_BEEF, 1'b0);

    issue(1'b1, SZ_W, 1'b0, 32'h20, 32'h0, "sw_20", 1'b1, 32'h0, 1'b0);
    issue(1'b1, SZ_B, 1'b0, 32'h21, 32'h0000_007F, "sb_21", 1'b1, 32'h0, 1'b0);
    issue(1'b1, SZ_H, 1'b0, 32'h22, 32'h0000_8001, "sh_22", 1'b1, 32'h0, 1'b0);
    issue(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, "lw_20", 1'b1, 32'h8001_7F00, 1'b0);

    issue(1'b1, SZ_H, 1'b0, 32'h03, 32'h0000_A5A5, "sh_03_misal", 1'b1, 32'h0, 1'b1);
    issue_m(1'b0, SZ_W, 1'b0, 32'h00, 32'h0, "lw_00_unchanged");
    issue(1'b0, SZ_W, 1'b0, 32'h102, 32'h0, "lw_102", 1'b1, 32'h0, 1'b1);
    issue(1'b0, SZ_W, 1'b0, SPAN, 32'h0, "lw_span", 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'b11, 1'b0, 32'h08, 32'h0, "ld_size11", 1'b1, 32'h0, 1'b1);
    issue(1'b1, 2'b11, 1'b0, 32'h08, 32'hFFFF_FFFF, "st_size11", 1'b1, 32'h0, 1'b1);
    issue_m(1'b0, SZ_W, 1'b0, 32'h08, 32'h0, "lw_08_unchanged");

    // Backpressure: three queued loads with resp_ready held low.
    drain();
    bp_mode = 1;
    @(posedge clk); #1;
    fork
      begin
        issue_m(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, "bp_lw");
        issue_m(1'b0, SZ_H, 1'b1, 32'h12, 32'h0, "bp_lhu");
        issue_m(1'b0, SZ_B, 1'b0, 32'h11, 32'h0, "bp_lb");
      end
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        for (int k = 0; k < 4; k++) begin
          chk1("bp_resp_valid", resp_valid, 1'b1);
          chk1("bp_req_ready", req_ready, 1'b0);
          if (k < 3) @(negedge clk);
        end
        bp_mode = 2;
      end
    join
    drain();
    bp_mode = 0;

    // Reset while a response is pending.
    drain();
    bp_mode = 1;
    @(posedge clk); #1;
    issue_m(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, "rst_pending_lw");
    #1;
    chk1("pre_rst_valid", resp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", resp_valid, 1'b0);
    chk1("mid_rst_ready", req_ready, 1'b0);
    chk("mid_rst_rdata", resp_rdata, 32'h0);
    chk1("mid_rst_err", resp_err, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bp_mode = 0;
    @(negedge clk);
    chk1("post_rst_ready", req_ready, 1'b1);
    chk1("post_rst_valid", resp_valid, 1'b0);
    issue_m(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, "post_rst_lw");

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          r;
      r  = $urandom_range(0, 99);
      sz = (r < 3) ? 2'b11 : 2'($urandom_range(0, 2));
      if (r >= 3 && r < 10) a = $urandom;
      else a = BASE + 32'($urandom_range(0, SPAN - 1));
      if (sz == SZ_W && $urandom_range(0, 9) != 0) a[1:0] = 2'b00;
      if (sz == SZ_H && $urandom_range(0, 9) != 0) a[0] = 1'b0;
      issue_m(1'($urandom), sz, 1'($urandom), a, $urandom, "rnd");
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    bp_mode = 2;
    drain();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
